// File: rtl/fft_pingpong_mem.sv
// Ping-pong sample buffer for an FFT stage: two banks alternate between a
// producer filling one bank and a consumer draining the other, with optional
// bit-reversed read addressing for radix-2 reordering.
module fft_pingpong_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_bitrev,
  input  logic              rd_release,
  output logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        level,
  output logic [1:0]        err
);

  // Both banks live in one array; the bank bit is the address MSB.
  logic [DATA_W-1:0] mem [2*DEPTH];

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        err_q;

  logic              wr_acc;
  logic              commit_acc;
  logic              rd_acc;
  logic              release_acc;
  logic              wr_bad;
  logic              rd_bad;
  logic [ADDR_W-1:0] rd_addr_eff;

  logic [DATA_W-1:0] rd_data_p1;
  logic              vld_p1;

  // Mirror the address bits: bit i moves to bit ADDR_W-1-i.
  function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

  assign wr_ready = !full[wr_bank];
  assign rd_ready = full[rd_bank];
  assign level    = 2'(full[0]) + 2'(full[1]);
  assign err      = err_q;
  assign rd_data  = rd_data_p1;
  assign rd_valid = vld_p1;

  // Requests are only honoured against a bank in the right state; anything
  // else is dropped and flagged.
  assign wr_acc      = wr_en      & wr_ready;
  assign commit_acc  = wr_commit  & wr_ready;
  assign rd_acc      = rd_en      & rd_ready;
  assign release_acc = rd_release & rd_ready;
  assign wr_bad      = (wr_en | wr_commit)  & !wr_ready;
  assign rd_bad      = (rd_en | rd_release) & !rd_ready;

  assign rd_addr_eff = rd_bitrev ? bit_reverse(rd_addr) : rd_addr;

  // Commit and release always target different banks when both are
  // accepted, so applying them in sequence is order-independent.
  always_comb begin
    full_nxt = full;
    if (commit_acc)  full_nxt[wr_bank] = 1'b1;
    if (release_acc) full_nxt[rd_bank] = 1'b0;
  end

  // Bank status, pointers, sticky errors and read-valid tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      full    <= 2'b00;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      err_q   <= 2'b00;
      vld_p1  <= 1'b0;
    end else begin
      full   <= full_nxt;
      err_q  <= err_q | {rd_bad, wr_bad};
      vld_p1 <= rd_acc;
      if (commit_acc)  wr_bank <= ~wr_bank;
      if (release_acc) rd_bank <= ~rd_bank;
    end
  end

  // Storage write; reset blocks the write but never clears contents.
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
  end

  // Stage p1: registered read data, held when no read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_p1 <= '0;
    end else if (rd_acc) begin
      rd_data_p1 <= mem[{rd_bank, rd_addr_eff}];
    end
  end

endmodule

// File: tb/tb_fft_pingpong_mem.sv
// Directed bench for fft_pingpong_mem: table-driven reads plus hand-written
// sequences for bank hand-over, overflow/underflow and reset behaviour.
module tb_fft_pingpong_mem;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam logic [31:0] KEY1 = 32'hA5A5_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_commit;
  logic              wr_ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_bitrev;
  logic              rd_release;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [1:0]        level;
  logic [1:0]        err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  addr;
    logic        bitrev;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [10];

  fft_pingpong_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_bitrev  (rd_bitrev),
    .rd_release (rd_release),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input int lvl, input int wrdy,
                            input int rrdy, input int e);
    chk({name, ".level"},    32'(level),    32'(lvl));
    chk({name, ".wr_ready"}, 32'(wr_ready), 32'(wrdy));
    chk({name, ".rd_ready"}, 32'(rd_ready), 32'(rrdy));
    chk({name, ".err"},      32'(err),      32'(e));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_commit = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_bitrev = 1'b0; rd_release = 1'b0;
  endtask

  // Fill the current write bank with addr^key; optionally commit (and
  // release the read bank) on the final write cycle.
  task automatic fill(input logic [31:0] key, input logic commit_last, input logic release_last);
    for (int i = 0; i < DEPTH; i++) begin
      wr_en      = 1'b1;
      wr_addr    = 8'(i);
      wr_data    = 32'(i) ^ key;
      wr_commit  = commit_last && (i == DEPTH-1);
      rd_release = release_last && (i == DEPTH-1);
      step();
    end
    idle();
  endtask

  task automatic rd(input string name, input logic [7:0] a, input logic br, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a; rd_bitrev = br;
    step();
    idle();
    chk({name, ".valid"}, 32'(rd_valid), 32'd1);
    chk({name, ".data"},  rd_data,       exp);
  endtask

  initial begin
    tbl[0] = '{8'h05, 1'b0, 32'h05};
    tbl[1] = '{8'h01, 1'b1, 32'h80};
    tbl[2] = '{8'h03, 1'b1, 32'hC0};
    tbl[3] = '{8'h00, 1'b0, 32'h00};
    tbl[4] = '{8'hFF, 1'b1, 32'hFF};
    tbl[5] = '{8'h80, 1'b1, 32'h01};
    tbl[6] = '{8'h0F, 1'b0, 32'h0F};
    tbl[7] = '{8'h0F, 1'b1, 32'hF0};
    tbl[8] = '{8'h12, 1'b1, 32'h48};
    tbl[9] = '{8'h12, 1'b0, 32'h12};

    idle();
    rst = 1'b1;
    step();
    step();
    chk_status("reset", 0, 1, 0, 0);
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.rd_data",  rd_data,       32'd0);
    idle();
    step();

    // Bank0 filled with word=addr, committed on the last write.
    fill(32'd0, 1'b1, 1'b0);
    chk_status("fill0", 1, 1, 1, 0);

    for (int i = 0; i < 10; i++) begin
      rd_en = 1'b1; rd_addr = tbl[i].addr; rd_bitrev = tbl[i].bitrev;
      step();
      idle();
      chk($sformatf("tbl[%0d].valid", i), 32'(rd_valid), 32'd1);
      chk($sformatf("tbl[%0d].data", i),  rd_data,       tbl[i].exp);
    end

    // No read: valid drops, data holds last value.
    step();
    chk("idle.valid", 32'(rd_valid), 32'd0);
    chk("idle.data",  rd_data,       32'h12);

    // Fill bank1, commit it and release bank0 in the same cycle.
    fill(KEY1, 1'b1, 1'b1);
    chk("swap.valid", 32'(rd_valid), 32'd0);
    chk_status("swap", 1, 1, 1, 0);
    rd("bank1.a4",  8'h04, 1'b0, KEY1 ^ 32'h04);
    rd("bank1.br2", 8'h02, 1'b1, KEY1 ^ 32'h40);

    // Bank0 gets one word and commits in the same cycle -> both full.
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 32'h11; wr_commit = 1'b1;
    step();
    idle();
    chk_status("both_full", 2, 0, 1, 0);

    // Overflow attempt: must not write or change state.
    wr_en = 1'b1; wr_addr = 8'h00; wr_data = 32'hDEAD_BEEF; wr_commit = 1'b1;
    step();
    idle();
    chk_status("overflow", 2, 0, 1, 1);

    // Release bank1 while reading it in the same cycle.
    rd_en = 1'b1; rd_addr = 8'h00; rd_release = 1'b1;
    step();
    idle();
    chk("rel1.valid", 32'(rd_valid), 32'd1);
    chk("rel1.data",  rd_data,       KEY1);
    chk_status("rel1", 1, 1, 1, 1);
    rd("bank0.a0", 8'h00, 1'b0, 32'h11);
    rd("bank0.a5", 8'h05, 1'b0, 32'h05);

    // Drain everything, then an underflow read.
    rd_release = 1'b1;
    step();
    idle();
    chk_status("empty", 0, 1, 0, 1);
    rd_en = 1'b1; rd_addr = 8'h07;
    step();
    idle();
    chk("underflow.valid", 32'(rd_valid), 32'd0);
    chk("underflow.data",  rd_data,       32'h05);
    chk_status("underflow", 0, 1, 0, 3);

    // Commit bank1 with a word, then reset with a read and a write pending.
    wr_en = 1'b1; wr_addr = 8'h03; wr_data = 32'h33; wr_commit = 1'b1;
    step();
    idle();
    chk_status("pre_rst", 1, 1, 1, 3);
    rst = 1'b1; rd_en = 1'b1; rd_addr = 8'h03; wr_en = 1'b1; wr_addr = 8'h05;
    wr_data = 32'h0BAD; wr_commit = 1'b1;
    step();
    idle();
    chk("rst.valid", 32'(rd_valid), 32'd0);
    chk("rst.data",  rd_data,       32'd0);
    chk_status("rst", 0, 1, 0, 0);

    // Read with nothing full right after reset.
    rd_en = 1'b1; rd_addr = 8'h01;
    step();
    idle();
    chk("rd_empty.valid", 32'(rd_valid), 32'd0);
    chk("rd_empty.data",  rd_data,       32'd0);
    chk_status("rd_empty", 0, 1, 0, 2);

    // Memory survives reset and the write during reset was blocked.
    wr_commit = 1'b1;
    step();
    idle();
    chk_status("recommit", 1, 1, 1, 2);
    rd("keep.a5", 8'h05, 1'b0, 32'h05);
    rd("keep.a0", 8'h00, 1'b0, 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_pingpong_mem.md
FFT_PINGPONG_MEM -- requirements
Module: fft_pingpong_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample word width (packed complex re/im).
REQ-002 SHALL have parameter DEPTH, default 256, words per bank; power of two, at least 4.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH), address width.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  in  1  write strobe into current write bank.
REQ-007 SHALL have port wr_addr  in  ADDR_W  write address.
REQ-008 SHALL have port wr_data  in  DATA_W  write data.
REQ-009 SHALL have port wr_commit  in  1  producer marks current write bank full.
REQ-010 SHALL have port wr_ready  out  1  current write bank is empty and writable.
REQ-011 SHALL have port rd_en  in  1  read strobe from current read bank.
REQ-012 SHALL have port rd_addr  in  ADDR_W  read address.
REQ-013 SHALL have port rd_bitrev  in  1  1 = bit-reverse rd_addr before lookup.
REQ-014 SHALL have port rd_release  in  1  consumer marks current read bank empty.
REQ-015 SHALL have port rd_ready  out  1  current read bank is full and readable.
REQ-016 SHALL have port rd_data  out  DATA_W  registered read data.
REQ-017 SHALL have port rd_valid  out  1  rd_data updated this cycle.
REQ-018 SHALL have port level  out  2  number of full banks (0..2).
REQ-019 SHALL have port err  out  2  sticky errors: bit0 write-side, bit1 read-side.

Function
REQ-020 SHALL hold two banks of DEPTH x DATA_W storage, plus state: full[1:0], wr_bank, rd_bank.
REQ-021 SHALL drive wr_ready = !full[wr_bank], rd_ready = full[rd_bank], level = full[0]+full[1], all combinationally from registers.
REQ-022 SHALL, on wr_en with wr_ready, write wr_data to bank wr_bank at wr_addr at the clock edge.
REQ-023 SHALL, on wr_commit with wr_ready, set full[wr_bank] and toggle wr_bank; wr_en in the same cycle writes the committing bank first.
REQ-024 SHALL, on rd_en with rd_ready, register bank rd_bank at effective address into rd_data and assert rd_valid the next cycle (latency 1).
REQ-025 SHALL use effective address = bit-reversed rd_addr (bit i to bit ADDR_W-1-i) when rd_bitrev=1, else rd_addr.
REQ-026 SHALL, on rd_release with rd_ready, clear full[rd_bank] and toggle rd_bank; rd_en in the same cycle reads the releasing bank.
REQ-027 SHALL hold rd_data unchanged and drive rd_valid=0 in any cycle following one without an accepted read.
REQ-028 SHALL accept commit of one bank and release of the other in the same cycle; level unchanged, both pointers toggle.
REQ-029 SHALL ignore wr_en/wr_commit while wr_ready=0 (no memory or state change) and set err[0].
REQ-030 SHALL ignore rd_en/rd_release while rd_ready=0 (rd_valid=0 next cycle) and set err[1].
REQ-031 SHALL keep err bits set until reset.
REQ-032 SHALL never allow wr_bank==rd_bank with mixed state; equal pointers imply level 0 or 2.

Reset
REQ-033 SHALL, on rst=1 at a clock edge, clear full, wr_bank, rd_bank, rd_data, rd_valid, err; hence wr_ready=1, rd_ready=0, level=0.
REQ-034 SHALL leave memory contents unreset; reset mid-fill or mid-drain discards bank status and any read in flight (rd_valid=0 next cycle).
REQ-035 SHALL give rst priority over all other inputs in the same cycle.

Verification
REQ-036 Fill bank0 with word=addr (0..255), commit, read addr 5 bitrev=0 -> rd_valid=1 next cycle, rd_data=5; level=1, wr_ready=1, rd_ready=1.
REQ-037 Same bank, read addr 1 bitrev=1 -> rd_data=128; addr 0x03 -> 0xC0.
REQ-038 Commit both banks without release -> level=2, wr_ready=0; extra wr_en to addr 0 -> bank data unchanged, err=01.
REQ-039 Level=1 (bank0 full, filling bank1): commit bank1 and release bank0 same cycle -> level=1, rd_bank=1, wr_bank=0, err=00.
REQ-040 rd_en with level=0 -> rd_valid=0 next cycle, rd_data held, err=10.
REQ-041 Assert rst after commit of bank0 -> level=0, wr_ready=1, rd_ready=0, err=00, rd_data=0.
